sn_to_bin_acc: RTL and testbench
================================

# sn_to_bin_acc

Stochastic-to-binary converter for the DSC datapath. It sits directly downstream of the counter-based SNGs and the max/min/median gate networks. It counts the 1s in an incoming unary stream over one window of 2^WIDTH bits, delivered STRIDE bits per enabled cycle. At the window boundary it latches the count into an output register that is drained through a valid/ready handshake.

## Interface
- WIDTH, 4: SNG counter width; one window is 2^WIDTH stream bits.
- STRIDE, 1: stream bits per enabled cycle; legal values 1, 2, 4; one window is 2^WIDTH/STRIDE groups.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  the current sn_in group is valid and is accumulated.
- sn_in  in  STRIDE  stream bits; bit 0 is the earliest bit.
- window_end  in  1  marks the final group of a window; qualified by en. Driven from the SNG ctr_overflow.
- count_out  out  WIDTH+1  number of 1s in the last completed window, 0..2^WIDTH.
- valid  out  1  count_out holds an unconsumed result.
- ready  in  1  consumer accepts count_out when valid && ready.
- err  out  1  present only with SN2BIN_CHK_EN; one-cycle error pulse.

## Operation
- FSM states:
  - IDLE: after reset; acc = 0.
  - ACCUM: entered on the first en cycle.
  - ACCUM → IDLE only by reset.
- Each cycle with en=1: the group contributes pc = popcount(sn_in), range 0..STRIDE.
  - window_end=0: acc <= acc + pc.
  - window_end=1: count_out <= acc + pc; acc <= 0; valid <= 1. The next window starts on the following en cycle with no gap.
- en=0: acc, count_out and the FSM hold; window_end is ignored.
- Arithmetic:
  - acc is WIDTH+1 bits.
  - An all-ones window yields exactly 2^WIDTH.
  - Overlong windows wrap modulo 2^(WIDTH+1); they are not saturated.
- Handshake:
  - valid clears on the cycle after a cycle with valid && ready, unless a new result loads that same cycle.
  - count_out is stable while valid=1 && ready=0, except on overwrite (below).
- Boundary cases:
  - Window end while valid=1 && ready=0 (overrun): the new count overwrites count_out and valid stays 1. The old result is lost.
  - Window end with valid && ready in the same cycle: the old result is consumed, the new result loads, and valid stays 1.
  - Window end in the very first en cycle: legal; the result is pc of that group only.
- Reset, mid-window or mid-handshake: immediately acc=0, count_out=0, valid=0, err=0, state IDLE. A partial window is discarded.

## Timing
- Reset values of all outputs: count_out 0, valid 0, err 0.
- Latency: window_end cycle at edge N → count_out/valid updated after edge N; visible in cycle N+1.
- Throughput: one window per 2^WIDTH/STRIDE en cycles. No bubble is required between windows.
- No combinational path from any input to any output; all outputs are registered.
- err (when compiled in) asserts in the cycle after the offending en cycle, for exactly one cycle.

## Configuration
- Macro SN2BIN_CHK_EN.
- Defined:
  - Adds an internal group counter, log2(2^WIDTH/STRIDE)+1 bits, cleared at reset and at each window end.
  - Adds the err output port.
  - err pulses on any of these:
    - (a) window_end arrives when the group count is not 2^WIDTH/STRIDE − 1 (the window is short);
    - (b) the group count reaches 2^WIDTH/STRIDE with no window_end; the counter then restarts the window check;
    - (c) an overrun occurs.
  - Data behaviour is identical to the undefined build.
- Undefined: no group counter and no err port; errors pass silently.

## Test plan
- WIDTH=4, STRIDE=1, upstream SNG bin_in=5, ready=1 → after the 16th en cycle (window_end), count_out=5 and valid=1 for one cycle. The next window, also bin_in=5, gives 5 again.
- WIDTH=4, STRIDE=2, sn_in=2'b11 for 8 cycles → count_out=16 (5'b10000), proving the WIDTH+1 width. sn_in=2'b00 for 8 cycles → count_out=0 with valid=1.
- Backpressure, ready=0: window A yields 3, then window B yields 9 → count_out=9, valid held across both. Raise ready → valid falls the next cycle. With CHK_EN, err pulses once at B.
- Gaps: toggle en randomly within a window of 16 ones; window_end asserted while en=0 is ignored → count_out=16. The result is unaffected by the gaps.
- Reset asserted asynchronously after 7 of 16 bits, then a full window of 4 ones → count_out=4. There is no residue from the partial window.
- CHK_EN: window_end at group 10 (STRIDE=1, WIDTH=4) → err pulses once and count_out equals the ones seen so far. A 17-group window without window_end → err pulses at group 16.

Source files
------------

// File: rtl/sn_to_bin_acc_if.sv
// sn_to_bin_acc_if: stream and result handshake bundle for sn_to_bin_acc.
//   en         : the current sn_in group is valid
//   sn_in      : STRIDE stream bits, bit 0 earliest
//   window_end : last group of a window (qualified by en)
//   count_out  : ones counted in the last completed window (WIDTH+1 bits)
//   valid      : count_out holds an unconsumed result
//   ready      : consumer accepts count_out when valid && ready
// master = stream producer / result consumer side, slave = converter side.
interface sn_to_bin_acc_if #(
    parameter int WIDTH  = 4,
    parameter int STRIDE = 1
);
    logic              en;
    logic [STRIDE-1:0] sn_in;
    logic              window_end;
    logic [WIDTH:0]    count_out;
    logic              valid;
    logic              ready;

    modport master (
        output en, sn_in, window_end, ready,
        input  count_out, valid
    );

    modport slave (
        input  en, sn_in, window_end, ready,
        output count_out, valid
    );
endinterface

// File: rtl/sn_to_bin_acc.sv
// sn_to_bin_acc: stochastic-to-binary converter. Counts the ones of a unary
// stream over one window of 2^WIDTH bits (STRIDE bits per enabled cycle) and
// latches the count into a valid/ready drained output register.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : sn_to_bin_acc_if.slave (en, sn_in, window_end, ready in;
//          count_out, valid out)
//   err  : one-cycle window/overrun error pulse, only with SN2BIN_CHK_EN
// Optional feature macro: SN2BIN_CHK_EN (window length and overrun checker).
module sn_to_bin_acc #(
    parameter int WIDTH  = 4,
    parameter int STRIDE = 1
) (
    input  logic            clk,
    input  logic            rst,
    sn_to_bin_acc_if.slave  bus
`ifdef SN2BIN_CHK_EN
    ,
    output logic            err
`endif
);

    localparam int unsigned STRIDE_U = STRIDE;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t         state;
    logic [WIDTH:0] acc;
    logic [WIDTH:0] count_r;
    logic           valid_r;
    logic [WIDTH:0] pc;
    logic [WIDTH:0] sum;

    // Popcount of the current group; sum wraps modulo 2^(WIDTH+1).
    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < STRIDE_U; i++) begin
            pc = pc + {{WIDTH{1'b0}}, bus.sn_in[i]};
        end
        sum = acc + pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            count_r <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (bus.en) state <= ACCUM;
                ACCUM:   state <= ACCUM;
                default: state <= IDLE;
            endcase

            // A consumed result drops valid unless a new one loads below.
            if (valid_r && bus.ready) valid_r <= 1'b0;

            if (bus.en) begin
                if (bus.window_end) begin
                    count_r <= sum;
                    acc     <= '0;
                    valid_r <= 1'b1;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    assign bus.count_out = count_r;
    assign bus.valid     = valid_r;

`ifdef SN2BIN_CHK_EN
    localparam int            GROUPS = (2 ** WIDTH) / STRIDE;
    localparam int            GW     = $clog2(GROUPS) + 1;
    localparam logic [GW-1:0] LAST   = GW'(GROUPS - 1);

    logic [GW-1:0] grp;

    // grp counts groups already seen in the current window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp <= '0;
            err <= 1'b0;
        end else begin
            err <= 1'b0;
            if (bus.en) begin
                if (bus.window_end) begin
                    grp <= '0;
                    if ((grp != LAST) || (valid_r && !bus.ready)) err <= 1'b1;
                end else if (grp == LAST) begin
                    // Full window seen without window_end: flag and restart.
                    err <= 1'b1;
                    grp <= '0;
                end else begin
                    grp <= grp + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sn_to_bin_acc.sv
module tb_sn_to_bin_acc;

    localparam int WIDTH  = 4;
    localparam int STRIDE = 2;
    localparam int GROUPS = (2 ** WIDTH) / STRIDE;
    localparam int MOD    = 2 ** (WIDTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sn_to_bin_acc_if #(.WIDTH(WIDTH), .STRIDE(STRIDE)) bus ();

`ifdef SN2BIN_CHK_EN
    logic err;
`endif

    sn_to_bin_acc #(.WIDTH(WIDTH), .STRIDE(STRIDE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SN2BIN_CHK_EN
        ,
        .err (err)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: scoreboard of expected results plus window bookkeeping.
    int q[$];
    bit exp_valid = 1'b0;
    int win_ones  = 0;
    int grp       = 0;
    bit exp_err   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one rising edge, evaluated with the inputs the DUT sampled.
    task automatic model_edge();
        bit ev;
        ev = exp_valid;
        exp_err = 1'b0;
        if (bus.en) begin
            win_ones += $countones(bus.sn_in);
            if (bus.window_end) begin
                exp_err = (grp != GROUPS - 1) || (ev && !bus.ready);
                grp = 0;
                if (ev && !bus.ready) void'(q.pop_back());
                q.push_back(win_ones % MOD);
                win_ones  = 0;
                exp_valid = 1'b1;
            end else begin
                if (grp == GROUPS - 1) begin
                    exp_err = 1'b1;
                    grp = 0;
                end else begin
                    grp++;
                end
                if (ev && bus.ready) exp_valid = 1'b0;
            end
        end else if (ev && bus.ready) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic step(input bit e, input logic [STRIDE-1:0] s, input bit we, input bit rdy);
        bus.en         = e;
        bus.sn_in      = s;
        bus.window_end = we;
        bus.ready      = rdy;
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        q.delete();
        exp_valid = 1'b0;
        win_ones  = 0;
        grp       = 0;
        exp_err   = 1'b0;
        #1;
        check("rst_count_out", 32'(bus.count_out), 0);
        check("rst_valid", 32'(bus.valid), 0);
`ifdef SN2BIN_CHK_EN
        check("rst_err", 32'(err), 0);
`endif
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    function automatic logic [STRIDE-1:0] pat(input int mode);
        logic [31:0] r;
        r = $urandom;
        case (mode)
            1:       return '1;
            2:       return '0;
            default: return r[STRIDE-1:0];
        endcase
    endfunction

    function automatic bit rdy(input int mode);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return $urandom_range(1) == 1;
        endcase
    endfunction

    // n enabled groups, window_end on the last; optional random en=0 gaps
    // carrying random (ignored) window_end values.
    task automatic window(input int n, input int gap_pct, input int rdy_mode, input int ones_mode);
        for (int g = 0; g < n; g++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct)
                step(1'b0, pat(0), $urandom_range(1) == 1, rdy(rdy_mode));
            step(1'b1, pat(ones_mode), g == n - 1, rdy(rdy_mode));
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard between edges.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid", 32'(bus.valid), 32'(exp_valid));
            if (exp_valid) begin
                check("count_out", 32'(bus.count_out), q[0]);
                if (bus.ready) void'(q.pop_front());
            end
`ifdef SN2BIN_CHK_EN
            check("err", 32'(err), 32'(exp_err));
`endif
        end
    end

    initial begin
        bus.en         = 1'b0;
        bus.sn_in      = '0;
        bus.window_end = 1'b0;
        bus.ready      = 1'b1;
        do_reset();

        // Plain windows, consumer always ready.
        repeat (3) window(GROUPS, 0, 1, 0);
        window(GROUPS, 0, 1, 1);           // all ones -> 2^WIDTH
        window(GROUPS, 0, 1, 2);           // all zeros -> 0, still valid

        // Backpressure: second window overruns the first, then drain.
        window(GROUPS, 0, 0, 0);
        window(GROUPS, 0, 0, 0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);

        // en gaps with stray window_end while disabled.
        window(GROUPS, 40, 1, 1);

        // Asynchronous reset mid-window, then a clean window.
        repeat (3) step(1'b1, '1, 1'b0, 1'b1);
        do_reset();
        window(GROUPS, 0, 1, 0);

        // Window end on the very first en cycle after reset.
        do_reset();
        window(1, 0, 1, 1);

        // Overlong window wraps modulo 2^(WIDTH+1); short window.
        window(20, 0, 1, 1);
        window(5, 0, 1, 0);

        // Random mix of lengths, gaps and backpressure.
        repeat (30) window($urandom_range(1, 12), $urandom_range(0, 30), 2, 0);

        repeat (4) step(1'b0, '0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
